// File: rtl/wireframe_buffer_ctrl_if.sv
// Rasterizer, display and SRAM signals of the wireframe buffer controller.
// master drives pixel requests and timing pulses; slave is the controller.
interface wireframe_buffer_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int XW     = 10,
  parameter int YW     = 9
);
  logic              px_valid;
  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;
  logic              px_ready;
  logic              frame_done;
  logic              vsync;
  logic              disp_en;
  logic              sram_write_en;
  logic              sram_data_in;
  logic              sram_flip;
  logic [ADDR_W-1:0] sram_write_addr;
  logic [ADDR_W-1:0] sram_read_addr;
  logic              clearing;
  logic              frame_drop;
  logic              oob_err;

  modport master (
    output px_valid, px_x, px_y, frame_done, vsync, disp_en,
    input  px_ready, sram_write_en, sram_data_in, sram_flip, sram_write_addr,
           sram_read_addr, clearing, frame_drop, oob_err
  );

  modport slave (
    input  px_valid, px_x, px_y, frame_done, vsync, disp_en,
    output px_ready, sram_write_en, sram_data_in, sram_flip, sram_write_addr,
           sram_read_addr, clearing, frame_drop, oob_err
  );
endinterface

// File: rtl/wireframe_buffer_ctrl.sv
// Double-buffered wireframe controller: clear back buffer, draw pixels, flip on vsync.
// Pixel writes land one cycle after handshake; px_ready is low outside DRAW.
module wireframe_buffer_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic                    clk,
  input  logic                    n_rst,
  wireframe_buffer_ctrl_if.slave  bus
);
  localparam int                NPIX      = WIDTH * HEIGHT;
  localparam int                CW        = ADDR_W + 1;
  localparam logic [CW-1:0]     LAST_CNT  = CW'(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {CLEAR, DRAW, WAIT_FLIP} state_t;

  state_t            state;
  logic [CW-1:0]     clr_cnt;
  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;
  logic              hs;
  logic              in_range;
  logic [ADDR_W-1:0] px_addr;

  assign px_x     = bus.px_x;
  assign px_y     = bus.px_y;
  assign hs       = bus.px_valid & bus.px_ready;
  assign in_range = (32'(px_x) < WIDTH) && (32'(px_y) < HEIGHT);
  assign px_addr  = ADDR_W'(px_y) * W_A + ADDR_W'(px_x);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state               <= CLEAR;
      clr_cnt             <= '0;
      bus.sram_read_addr  <= '0;
      bus.sram_write_en   <= 1'b0;
      bus.sram_data_in    <= 1'b0;
      bus.sram_write_addr <= '0;
      bus.sram_flip       <= 1'b0;
      bus.px_ready        <= 1'b0;
      bus.frame_drop      <= 1'b0;
      bus.oob_err         <= 1'b0;
      bus.clearing        <= 1'b1;
    end else begin
      bus.sram_write_en <= 1'b0;
      bus.sram_data_in  <= 1'b0;
      bus.sram_flip     <= 1'b0;
      bus.frame_drop    <= 1'b0;

      // vsync restarts the display scan and wins over disp_en
      if (bus.vsync)
        bus.sram_read_addr <= '0;
      else if (bus.disp_en)
        bus.sram_read_addr <= (bus.sram_read_addr == LAST_ADDR) ? '0 : bus.sram_read_addr + 1'b1;

      case (state)
        CLEAR: begin
          if (bus.vsync) bus.frame_drop <= 1'b1;
          if (clr_cnt == LAST_CNT) begin
            state        <= DRAW;
            bus.px_ready <= 1'b1;
            bus.clearing <= 1'b0;
          end else begin
            bus.sram_write_en   <= 1'b1;
            bus.sram_write_addr <= clr_cnt[ADDR_W-1:0];
            clr_cnt             <= clr_cnt + 1'b1;
            bus.clearing        <= 1'b1;
          end
        end
        DRAW: begin
          if (bus.vsync) bus.frame_drop <= 1'b1;
          if (hs) begin
            if (in_range) begin
              bus.sram_write_en   <= 1'b1;
              bus.sram_data_in    <= 1'b1;
              bus.sram_write_addr <= px_addr;
            end else begin
              bus.oob_err <= 1'b1;
            end
          end
          if (bus.frame_done) begin
            state        <= WAIT_FLIP;
            bus.px_ready <= 1'b0;
          end
        end
        WAIT_FLIP: begin
          // flip cycle issues no write, so clearing starts on the new back buffer
          if (bus.vsync) begin
            bus.sram_flip <= 1'b1;
            state         <= CLEAR;
            clr_cnt       <= '0;
            bus.clearing  <= 1'b1;
          end
        end
        default: begin
          state        <= CLEAR;
          clr_cnt      <= '0;
          bus.px_ready <= 1'b0;
          bus.clearing <= 1'b1;
        end
      endcase
    end
  end
endmodule
